// File: rtl/typedefs_v2.sv
// Shared VeriRISC types: opcodes, controller phases, strobe bundle and the
// controller's internal state encoding.
package typedefs_v2;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } ctrl_phase_t;

  typedef struct packed {
    logic mem_rd;
    logic load_ir;
    logic inc_pc;
    logic load_ac;
    logic load_pc;
    logic mem_wr;
    logic halt;
  } ctrl_strobe_t;

  // Low three bits of the eight sequencing states equal their phase code.
  typedef enum logic [3:0] {
    ST_INST_ADDR  = 4'd0,
    ST_INST_FETCH = 4'd1,
    ST_INST_LOAD  = 4'd2,
    ST_IDLE       = 4'd3,
    ST_OP_ADDR    = 4'd4,
    ST_OP_FETCH   = 4'd5,
    ST_ALU_OP     = 4'd6,
    ST_STORE      = 4'd7,
    ST_HALTED     = 4'd8,
    ST_STEP_WAIT  = 4'd9
  } ctrl_state_t;

  function automatic logic is_aluop(input opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/veririsc_ctrl_decode.sv
// Combinational strobe decode from the current phase, opcode and ALU zero flag.
module veririsc_ctrl_decode
  import typedefs_v2::*;
(
  input  ctrl_phase_t  phase,
  input  opcode_t      opcode,
  input  logic         zero,
  output ctrl_strobe_t strobes
);

  logic aluop;

  assign aluop = is_aluop(opcode);

  always_comb begin
    strobes = '0;
    case (phase)
      INST_FETCH: strobes.mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        strobes.mem_rd  = 1'b1;
        strobes.load_ir = 1'b1;
      end
      OP_ADDR: begin
        strobes.inc_pc = 1'b1;
        strobes.halt   = (opcode == HLT);
      end
      OP_FETCH: strobes.mem_rd = aluop;
      ALU_OP: begin
        strobes.mem_rd  = aluop;
        strobes.load_ac = aluop;
        strobes.inc_pc  = (opcode == SKZ) && zero;
        strobes.load_pc = (opcode == JMP);
      end
      STORE: begin
        strobes.mem_rd  = aluop;
        strobes.load_ac = aluop;
        strobes.inc_pc  = (opcode == JMP);
        strobes.load_pc = (opcode == JMP);
        strobes.mem_wr  = (opcode == STO);
      end
      default: strobes = '0;
    endcase
  end

endmodule

// File: rtl/veririsc_ctrl.sv
// VeriRISC instruction sequencer: 8-phase FSM plus HALTED and, when
// VERIRISC_CTRL_STEP_EN is defined, a STEP_WAIT single-step state after STORE.
module veririsc_ctrl
  import typedefs_v2::*;
#(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] opcode,
`ifdef VERIRISC_CTRL_STEP_EN
  input  logic       step,
`endif
  input  logic       zero,
  output logic       mem_rd,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_ac,
  output logic       load_pc,
  output logic       mem_wr,
  output logic       halt,
  output logic [2:0] phase,
  output logic       instr_done
);

  ctrl_state_t  state, state_next;
  ctrl_phase_t  cur_phase;
  opcode_t      op;
  ctrl_strobe_t dec_strobes, strobes;

  assign op = opcode_t'(opcode);

  // HALTED reports the OP_ADDR code; STEP_WAIT keeps reporting STORE.
  assign cur_phase = (state == ST_HALTED)    ? OP_ADDR :
                     (state == ST_STEP_WAIT) ? STORE   :
                     ctrl_phase_t'(state[2:0]);

  veririsc_ctrl_decode u_decode (
    .phase   (cur_phase),
    .opcode  (op),
    .zero    (zero),
    .strobes (dec_strobes)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INST_ADDR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    strobes    = '0;
    instr_done = 1'b0;
    case (state)
      ST_HALTED: strobes.halt = 1'b1;
`ifdef VERIRISC_CTRL_STEP_EN
      ST_STEP_WAIT: begin
        if (en && step) state_next = ST_INST_ADDR;
      end
`endif
      default: begin
        if (en) begin
          strobes    = dec_strobes;
          instr_done = (cur_phase == STORE);
          if (cur_phase == OP_ADDR && op == HLT && HALT_STICKY) begin
            state_next = ST_HALTED;
          end else if (cur_phase == STORE) begin
`ifdef VERIRISC_CTRL_STEP_EN
            state_next = ST_STEP_WAIT;
`else
            state_next = ST_INST_ADDR;
`endif
          end else begin
            state_next = ctrl_state_t'({1'b0, 3'(cur_phase + 3'd1)});
          end
        end
      end
    endcase
  end

  assign mem_rd  = strobes.mem_rd;
  assign load_ir = strobes.load_ir;
  assign inc_pc  = strobes.inc_pc;
  assign load_ac = strobes.load_ac;
  assign load_pc = strobes.load_pc;
  assign mem_wr  = strobes.mem_wr;
  assign halt    = strobes.halt;
  assign phase   = cur_phase;

endmodule

// File: tb/tb_veririsc_ctrl.sv
// Bench for veririsc_ctrl: sticky (dut0) and non-sticky (dut1) halt builds
// side by side, checked against a phase-mask reference model.
module tb_veririsc_ctrl;
  import typedefs_v2::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] opcode;
  logic       zero;
`ifdef VERIRISC_CTRL_STEP_EN
  logic       step;
`endif

  wire [6:0] s0, s1;
  wire [2:0] p0, p1;
  wire       d0, d1;

  int checks = 0;
  int errors = 0;

  int mph[2];
  bit mhalt[2];
  bit mwait[2];

  logic [6:0] last_s[2];
  logic [2:0] last_p[2];
  logic       last_d[2];

  always #5 clk = ~clk;

  veririsc_ctrl #(.HALT_STICKY(1'b1)) dut0 (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode),
`ifdef VERIRISC_CTRL_STEP_EN
    .step(step),
`endif
    .zero(zero),
    .mem_rd(s0[6]), .load_ir(s0[5]), .inc_pc(s0[4]), .load_ac(s0[3]),
    .load_pc(s0[2]), .mem_wr(s0[1]), .halt(s0[0]),
    .phase(p0), .instr_done(d0)
  );

  veririsc_ctrl #(.HALT_STICKY(1'b0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode),
`ifdef VERIRISC_CTRL_STEP_EN
    .step(step),
`endif
    .zero(zero),
    .mem_rd(s1[6]), .load_ir(s1[5]), .inc_pc(s1[4]), .load_ac(s1[3]),
    .load_pc(s1[2]), .mem_wr(s1[1]), .halt(s1[0]),
    .phase(p1), .instr_done(d1)
  );

  typedef struct {
    opcode_t    op;
    logic       z;
    logic [7:0] rd, ir, inc, ac, pc, wr, hl, done;
  } vec_t;

  task automatic checkEq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Each strobe as an 8-bit mask over phase codes for a given opcode.
  function automatic logic [6:0] expStrobes(input int ph, input opcode_t op, input logic z);
    logic [7:0] rdm, irm, incm, acm, pcm, wrm, hlm;
    logic aluop;
    aluop = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    rdm  = aluop ? 8'hEE : 8'h0E;
    irm  = 8'h0C;
    incm = 8'h10 | ((op == SKZ && z) ? 8'h40 : 8'h00) | ((op == JMP) ? 8'h80 : 8'h00);
    acm  = aluop ? 8'hC0 : 8'h00;
    pcm  = (op == JMP) ? 8'hC0 : 8'h00;
    wrm  = (op == STO) ? 8'h80 : 8'h00;
    hlm  = (op == HLT) ? 8'h10 : 8'h00;
    return {rdm[ph], irm[ph], incm[ph], acm[ph], pcm[ph], wrm[ph], hlm[ph]};
  endfunction

  task automatic checkOutput(input int k, input logic [6:0] s, input logic d, input logic [2:0] p,
                             input logic e, input opcode_t op, input logic z);
    logic [6:0] es;
    logic       ed;
    string      nm;
    nm = (k == 0) ? "dut0" : "dut1";
    if (mhalt[k]) begin
      es = 7'b0000001; ed = 1'b0;
      checkEq({nm, " phase"}, int'(p), 4);
    end else if (mwait[k]) begin
      es = '0; ed = 1'b0;
    end else begin
      es = e ? expStrobes(mph[k], op, z) : 7'b0;
      ed = e && (mph[k] == 7);
      checkEq({nm, " phase"}, int'(p), mph[k]);
    end
    checkEq({nm, " strobes"}, int'(s), int'(es));
    checkEq({nm, " instr_done"}, int'(d), int'(ed));
  endtask

  task automatic advanceModel(input int k, input logic e, input opcode_t op, input logic s);
    if (mhalt[k] || !e) return;
    if (mwait[k]) begin
      if (s) begin mwait[k] = 1'b0; mph[k] = 0; end
    end else if (mph[k] == 4 && op == HLT && k == 0) begin
      mhalt[k] = 1'b1;
    end else if (mph[k] == 7) begin
`ifdef VERIRISC_CTRL_STEP_EN
      mwait[k] = 1'b1;
`else
      mph[k] = 0;
`endif
    end else begin
      mph[k] = mph[k] + 1;
    end
  endtask

  // Called at posedge+1; checks at negedge, then advances across the next edge.
  task automatic applyStimulus(input logic e, input opcode_t op, input logic z, input logic s);
    en = e; opcode = op; zero = z;
`ifdef VERIRISC_CTRL_STEP_EN
    step = s;
`endif
    @(negedge clk);
    checkOutput(0, s0, d0, p0, e, op, z);
    checkOutput(1, s1, d1, p1, e, op, z);
    last_s[0] = s0; last_p[0] = p0; last_d[0] = d0;
    last_s[1] = s1; last_p[1] = p1; last_d[1] = d1;
    @(posedge clk);
    #1;
    advanceModel(0, e, op, s);
    advanceModel(1, e, op, s);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear with no clock.
  task automatic doReset();
    rst = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin mph[k] = 0; mhalt[k] = 1'b0; mwait[k] = 1'b0; end
    checkEq("reset dut0 phase", int'(p0), 0);
    checkEq("reset dut0 strobes", int'(s0), 0);
    checkEq("reset dut0 done", int'(d0), 0);
    checkEq("reset dut1 phase", int'(p1), 0);
    checkEq("reset dut1 strobes", int'(s1), 0);
    rst = 1'b0;
    #1;
  endtask

  task automatic finishStep(input opcode_t op);
`ifdef VERIRISC_CTRL_STEP_EN
    applyStimulus(1'b1, op, 1'b0, 1'b1);
`endif
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{ADD, 1'b0, 8'hEE, 8'h0C, 8'h10, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h80};
    vecs[1] = '{SKZ, 1'b1, 8'h0E, 8'h0C, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
    vecs[2] = '{SKZ, 1'b0, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
    vecs[3] = '{JMP, 1'b1, 8'h0E, 8'h0C, 8'h90, 8'h00, 8'hC0, 8'h00, 8'h00, 8'h80};
    vecs[4] = '{STO, 1'b1, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h80, 8'h00, 8'h80};
    vecs[5] = '{LDA, 1'b1, 8'hEE, 8'h0C, 8'h10, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h80};
    vecs[6] = '{XOR, 1'b0, 8'hEE, 8'h0C, 8'h10, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h80};
    vecs[7] = '{AND, 1'b1, 8'hEE, 8'h0C, 8'h10, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h80};

    rst = 1'b1; en = 1'b0; opcode = 3'd0; zero = 1'b0;
`ifdef VERIRISC_CTRL_STEP_EN
    step = 1'b0;
`endif
    @(posedge clk);
    #1;
    doReset();

    $display("[TB] table-driven instructions");
    foreach (vecs[i]) begin
      for (int p = 0; p < 8; p++) begin
        applyStimulus(1'b1, vecs[i].op, vecs[i].z, 1'b0);
        checkEq($sformatf("table %0d phase", i), int'(last_p[0]), p);
        checkEq($sformatf("table %0d strobes p%0d", i, p), int'(last_s[0]),
                int'({vecs[i].rd[p], vecs[i].ir[p], vecs[i].inc[p], vecs[i].ac[p],
                      vecs[i].pc[p], vecs[i].wr[p], vecs[i].hl[p]}));
        checkEq($sformatf("table %0d done p%0d", i, p), int'(last_d[0]), int'(vecs[i].done[p]));
      end
      finishStep(vecs[i].op);
    end

    $display("[TB] stall during INST_FETCH");
    doReset();
    applyStimulus(1'b1, ADD, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, ADD, 1'b0, 1'b0);
      checkEq("stall phase", int'(last_p[0]), 1);
      checkEq("stall mem_rd", int'(last_s[0][6]), 0);
    end
    applyStimulus(1'b1, ADD, 1'b0, 1'b0);
    checkEq("resume phase", int'(last_p[0]), 1);
    checkEq("resume mem_rd", int'(last_s[0][6]), 1);
    for (int c = 0; c < 6; c++) applyStimulus(1'b1, ADD, 1'b0, 1'b0);
    finishStep(ADD);

    $display("[TB] reset mid ALU_OP");
    for (int c = 0; c < 6; c++) applyStimulus(1'b1, ADD, 1'b1, 1'b0);
    checkEq("pre-reset phase", int'(p0), 6);
    checkEq("pre-reset load_ac", int'(s0[3]), 1);
    doReset();

    $display("[TB] HLT");
    for (int c = 0; c < 4; c++) applyStimulus(1'b1, ADD, 1'b0, 1'b0);
    applyStimulus(1'b1, HLT, 1'b0, 1'b0);
    checkEq("hlt dut0 halt", int'(last_s[0][0]), 1);
    checkEq("hlt dut1 halt", int'(last_s[1][0]), 1);
    applyStimulus(1'b1, ADD, 1'b0, 1'b0);
    checkEq("hlt dut1 next phase", int'(last_p[1]), 5);
    checkEq("hlt dut1 halt pulse", int'(last_s[1][0]), 0);
    for (int c = 0; c < 22; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), opcode_t'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkEq("sticky halt", int'(last_s[0]), 1);
    end

`ifdef VERIRISC_CTRL_STEP_EN
    $display("[TB] single step");
    doReset();
    for (int c = 0; c < 7; c++) applyStimulus(1'b1, LDA, 1'b0, 1'b0);
    applyStimulus(1'b1, LDA, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, LDA, 1'b0, 1'b0);
      checkEq("step wait strobes", int'(last_s[0]), 0);
    end
    applyStimulus(1'b0, LDA, 1'b0, 1'b1);
    applyStimulus(1'b1, LDA, 1'b0, 1'b1);
    checkEq("step release phase", int'(p0), 0);
`endif

    $display("[TB] random stimulus");
    doReset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) doReset();
      else applyStimulus(1'($urandom_range(0, 3) != 0), opcode_t'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
